// File: rtl/shunt_tlm_mem_pkg.sv
// Shared types for the TLM memory slave: command encoding, TLM response codes,
// FSM states and the byte-lane mask helper.
package shunt_tlm_mem_pkg;

    typedef enum logic [1:0] {
        CMD_READ   = 2'd0,
        CMD_WRITE  = 2'd1,
        CMD_IGNORE = 2'd2
    } tlm_cmd_e;

    localparam logic [1:0] CMD_ILLEGAL = 2'd3;

    // Signed 3-bit encodings of the SHUNT TLM response codes.
    localparam logic signed [2:0] TLM_INCOMPLETE_RESPONSE    = 3'sd0;
    localparam logic signed [2:0] TLM_OK_RESPONSE            = 3'sd1;
    localparam logic signed [2:0] TLM_ADDRESS_ERROR_RESPONSE = -3'sd2;
    localparam logic signed [2:0] TLM_COMMAND_ERROR_RESPONSE = -3'sd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/tlm_sp_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read data, no reset.
module tlm_sp_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tlm_mem_slave.sv
// Memory slave behind the TLM target: one transaction at a time, byte-enable
// read-modify-write on a single-port RAM, TLM response status and statistics.
module tlm_mem_slave
    import shunt_tlm_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_cmd_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic [3:0]        req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic signed [2:0] rsp_status_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH) << 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic signed [2:0] rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;

    logic              ram_re;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;
    logic [31:0]       be_mask;
    logic              rsp_hs;
    logic              addr_bad;

    // The registered write lands one cycle after WR; no read is ever issued then.
    assign ram_addr = ram_we_q ? widx_q : req_addr_i[AW+1:2];
    assign be_mask  = lane_mask(be_q);
    assign rsp_hs   = rsp_valid_q && rsp_ready_i;
    assign addr_bad = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ADDR_LIMIT);

    tlm_sp_ram #(.DEPTH(DEPTH), .DATA_W(32)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_q),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        err_cnt_d    = err_cnt_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        cmd_d        = cmd_q;
        widx_d       = widx_q;
        data_d       = data_q;
        be_d         = be_q;
        ram_re       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    cmd_d        = req_cmd_i;
                    widx_d       = req_addr_i[AW+1:2];
                    data_d       = req_data_i;
                    be_d         = req_be_i;
                    rsp_data_d   = '0;
                    rsp_status_d = TLM_OK_RESPONSE;
                    if (req_cmd_i == CMD_ILLEGAL) begin
                        rsp_status_d = TLM_COMMAND_ERROR_RESPONSE;
                        state_d      = ST_RSP;
                    end else if (req_cmd_i == CMD_IGNORE) begin
                        state_d = ST_RSP;
                    end else if (addr_bad) begin
                        rsp_status_d = TLM_ADDRESS_ERROR_RESPONSE;
                        state_d      = ST_RSP;
                    end else if (req_cmd_i == CMD_WRITE && req_be_i == 4'h0) begin
                        state_d = ST_RSP;
                    end else if (req_cmd_i == CMD_WRITE && req_be_i == 4'hF) begin
                        state_d = ST_WR;
                    end else begin
                        ram_re  = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cmd_q == CMD_READ) begin
                    rsp_data_d = ram_rdata & be_mask;
                    state_d    = ST_RSP;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                ram_wdata_d = (data_q & be_mask) | (ram_rdata & ~be_mask);
                ram_we_d    = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                    if (rsp_status_q != TLM_OK_RESPONSE) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else if (cmd_q == CMD_READ) begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end else if (cmd_q == CMD_WRITE) begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        // Valid trails entry into RSP by one cycle so outputs come straight from flops.
        rsp_valid_d = (state_q == ST_RSP) && !rsp_hs;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= TLM_INCOMPLETE_RESPONSE;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            err_cnt_q    <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ram_we_q     <= ram_we_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cmd_q       <= cmd_d;
        widx_q      <= widx_d;
        data_q      <= data_d;
        be_q        <= be_d;
        ram_wdata_q <= ram_wdata_d;
    end

    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_tlm_mem_slave.sv
// Bench for tlm_mem_slave: directed scenarios plus randomized traffic against a
// word-array reference model of the memory, status rules, latencies and counters.
module tb_tlm_mem_slave;

    localparam int CNT_W = 16;
    localparam logic signed [2:0] S_INC  = 3'sb000;
    localparam logic signed [2:0] S_OK   = 3'sb001;
    localparam logic signed [2:0] S_ADDR = 3'sb110;
    localparam logic signed [2:0] S_CMD  = 3'sb101;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_cmd_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_data_i;
    logic [3:0]        req_be_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [31:0]       rsp_data_o;
    logic signed [2:0] rsp_status_o;
    logic [CNT_W-1:0]  rd_cnt_o, wr_cnt_o, err_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [int];
    int m_rd = 0, m_wr = 0, m_err = 0;

    tlm_mem_slave #(.DEPTH(256), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_cmd_i    (req_cmd_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_be_i     (req_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .rd_cnt_o     (rd_cnt_o),
        .wr_cnt_o     (wr_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference: what a transaction should return, how long it takes, and its effect.
    task automatic model(input txn_t t, output logic [31:0] d,
                         output logic signed [2:0] s, output int lat);
        int w;
        logic [31:0] m;
        w = int'(t.addr >> 2);
        m = byte_mask(t.be);
        d = '0;
        s = S_OK;
        if (t.cmd == 2'd3) begin
            s = S_CMD; lat = 1; m_err++;
        end else if (t.cmd == 2'd2) begin
            lat = 1;
        end else if (t.addr % 4 != 0 || t.addr >= 32'd1024) begin
            s = S_ADDR; lat = 1; m_err++;
        end else if (t.cmd == 2'd0) begin
            d = mem_m[w] & m; lat = 2; m_rd++;
        end else begin
            lat = (t.be == 4'h0) ? 1 : (t.be == 4'hF) ? 2 : 3;
            if (t.be != 4'h0) mem_m[w] = (t.data & m) | (mem_m[w] & ~m);
            m_wr++;
        end
    endtask

    // Presents a request and waits (bounded) for rsp_valid_o; rsp_ready_i stays low.
    task automatic issue(input txn_t t, output int lat);
        int guard;
        guard = 0;
        rsp_ready_i = 1'b0;
        while (req_ready_o !== 1'b1 && guard < 20) begin
            @(posedge clk_i); #1; guard++;
        end
        req_valid_i = 1'b1;
        req_cmd_i   = t.cmd;
        req_addr_i  = t.addr;
        req_data_i  = t.data;
        req_be_i    = t.be;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_cmd_i   = 2'($urandom);
        req_addr_i  = $urandom;
        req_data_i  = $urandom;
        req_be_i    = 4'($urandom);
        lat = 0;
        do begin
            @(posedge clk_i); #1; lat++;
        end while (rsp_valid_o !== 1'b1 && lat < 12);
        if (rsp_valid_o !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid_o=%b after %0d cycles, want 1", rsp_valid_o, lat);
        end
    endtask

    task automatic do_txn(input txn_t t, input int hold, output logic [31:0] d,
                          output logic signed [2:0] s, output int lat);
        issue(t, lat);
        d = rsp_data_o;
        s = rsp_status_o;
        repeat (hold) begin @(posedge clk_i); #1; end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        n_tests++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        n_tests++; if (rsp_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
        n_tests++; if (rsp_status_o !== S_INC) begin n_fail++; $display("FAIL reset_status: got %0d want %0d", rsp_status_o, S_INC); end
        n_tests++;
        if ({rd_cnt_o, wr_cnt_o, err_cnt_o} !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", rd_cnt_o, wr_cnt_o, err_cnt_o);
        end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // Runs a list of transactions and checks each response plus the final counters.
    task automatic test_sequence(input string name, input txn_t tbl [$]);
        logic [31:0] ed, ad;
        logic signed [2:0] es, as_;
        int el, al;
        foreach (tbl[i]) begin
            model(tbl[i], ed, es, el);
            do_txn(tbl[i], 0, ad, as_, al);
            n_tests++; if (as_ !== es) begin n_fail++; $display("FAIL %s[%0d] status: got %0d want %0d", name, i, as_, es); end
            n_tests++; if (ad !== ed) begin n_fail++; $display("FAIL %s[%0d] data: got %h want %h", name, i, ad, ed); end
            n_tests++; if (al != el) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, al, el); end
            n_tests++;
            if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL %s[%0d] after_handshake: ready=%b valid=%b want 1/0", name, i, req_ready_o, rsp_valid_o);
            end
        end
        n_tests++;
        if (rd_cnt_o !== CNT_W'(m_rd) || wr_cnt_o !== CNT_W'(m_wr) || err_cnt_o !== CNT_W'(m_err)) begin
            n_fail++;
            $display("FAIL %s counters: got rd=%0d wr=%0d err=%0d want rd=%0d wr=%0d err=%0d",
                     name, rd_cnt_o, wr_cnt_o, err_cnt_o, m_rd, m_wr, m_err);
        end
    endtask

    task automatic test_full_rw();
        txn_t q[$];
        q = '{'{2'd1, 32'h10, 32'hDEADBEEF, 4'hF}, '{2'd0, 32'h10, 32'h0, 4'hF}};
        test_sequence("full_rw", q);
    endtask

    task automatic test_partial();
        txn_t q[$];
        q = '{'{2'd1, 32'h10, 32'h11223344, 4'b0101}, '{2'd0, 32'h10, 32'h0, 4'hF},
              '{2'd0, 32'h10, 32'h0, 4'b0011}};
        test_sequence("partial", q);
    endtask

    task automatic test_addr_errors();
        txn_t q[$];
        q = '{'{2'd1, 32'h3FC, 32'hCAFEF00D, 4'hF}, '{2'd0, 32'h3FC, 32'h0, 4'hF},
              '{2'd0, 32'h400, 32'h0, 4'hF}, '{2'd1, 32'h12, 32'hFFFFFFFF, 4'hF},
              '{2'd0, 32'h10, 32'h0, 4'hF}};
        test_sequence("addr_err", q);
    endtask

    task automatic test_cmd_ignore();
        txn_t q[$];
        q = '{'{2'd3, 32'h10, 32'h0, 4'hF}, '{2'd2, 32'h10, 32'h12345678, 4'hF},
              '{2'd1, 32'h10, 32'h0, 4'h0}, '{2'd0, 32'h10, 32'h0, 4'hF}};
        test_sequence("cmd_ignore", q);
    endtask

    task automatic test_backpressure();
        txn_t t;
        logic [31:0] ed, snap_d;
        logic signed [2:0] es, snap_s;
        int el, al;
        t = '{2'd0, 32'h10, 32'h0, 4'hF};
        model(t, ed, es, el);
        issue(t, al);
        snap_d = rsp_data_o;
        snap_s = rsp_status_o;
        n_tests++; if (snap_d !== ed) begin n_fail++; $display("FAIL backpressure data: got %h want %h", snap_d, ed); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            n_tests++;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== snap_d || rsp_status_o !== snap_s || req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure hold[%0d]: valid=%b data=%h status=%0d ready=%b want 1/%h/%0d/0",
                         c, rsp_valid_o, rsp_data_o, rsp_status_o, req_ready_o, snap_d, snap_s);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL backpressure release: valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_random();
        txn_t q[$];
        txn_t t;
        int ws [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 255};
        logic [31:0] ed, ad;
        logic signed [2:0] es, as_;
        int el, al, kind, w;
        foreach (ws[i]) q.push_back('{2'd1, 32'(ws[i] * 4), $urandom, 4'hF});
        test_sequence("rand_init", q);
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            w = ws[$urandom_range(0, 8)];
            t.addr = 32'(w * 4);
            t.data = $urandom;
            t.be   = 4'($urandom);
            if (kind <= 3) t.cmd = 2'd0;
            else if (kind <= 6) t.cmd = 2'd1;
            else if (kind == 7) begin t.cmd = 2'd2; t.addr = $urandom; end
            else if (kind == 8) begin t.cmd = 2'd3; t.addr = $urandom; end
            else begin
                t.cmd = 2'($urandom_range(0, 1));
                t.addr = ($urandom_range(0, 1) == 1) ? t.addr + 32'($urandom_range(1, 3))
                                                     : 32'd1024 + 32'($urandom_range(0, 1000) * 4);
            end
            model(t, ed, es, el);
            do_txn(t, $urandom_range(0, 2), ad, as_, al);
            n_tests++; if (as_ !== es) begin n_fail++; $display("FAIL random[%0d] status: got %0d want %0d", n, as_, es); end
            n_tests++; if (ad !== ed) begin n_fail++; $display("FAIL random[%0d] data: got %h want %h", n, ad, ed); end
            n_tests++; if (al != el) begin n_fail++; $display("FAIL random[%0d] latency: got %0d want %0d", n, al, el); end
        end
        n_tests++;
        if (rd_cnt_o !== CNT_W'(m_rd) || wr_cnt_o !== CNT_W'(m_wr) || err_cnt_o !== CNT_W'(m_err)) begin
            n_fail++;
            $display("FAIL random counters: got rd=%0d wr=%0d err=%0d want rd=%0d wr=%0d err=%0d",
                     rd_cnt_o, wr_cnt_o, err_cnt_o, m_rd, m_wr, m_err);
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        txn_t q[$];
        int al;
        t = '{2'd0, 32'h10, 32'h0, 4'hF};
        issue(t, al);
        #2 rst_n_i = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || {rd_cnt_o, wr_cnt_o, err_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b ready=%b cnt=%0d/%0d/%0d want 0/1/0/0/0",
                     rsp_valid_o, req_ready_o, rd_cnt_o, wr_cnt_o, err_cnt_o);
        end
        m_rd = 0; m_wr = 0; m_err = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        q = '{'{2'd0, 32'h10, 32'h0, 4'hF}};
        test_sequence("after_reset", q);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        req_valid_i = 1'b0;
        req_cmd_i   = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_full_rw();
        test_partial();
        test_addr_errors();
        test_cmd_ignore();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
